sid_audio_i2s_tx: RTL and testbench
===================================

// Module: sid_audio_i2s_tx
// PURPOSE
// - Sink for the SID filter/mixer output: captures signed 20-bit stereo audio (one value per SID chip)
//   on a strobe and serialises it as a standard I2S stream (64 BCK/frame, 2 x 32-bit slots) to the DAC.
// - Decouples the SID sample rate from the I2S frame rate via a one-deep holding register.
// PARAMETERS
// - CLK_DIV    2   clk cycles per BCK half-period (>=1); BCK = clk/(2*CLK_DIV)
// PORTS
// - clk           in   1   system clock; all logic on posedge
// - rst_n         in   1   asynchronous active-low reset
// - audio_valid   in   1   one-cycle strobe: audio_l/audio_r valid (issued when filter stage 7 result is ready)
// - audio_l       in   20  sid::s20_t, left sample (SID 1)
// - audio_r       in   20  sid::s20_t, right sample (SID 2)
// - i2s_bck       out  1   bit clock
// - i2s_lrck      out  1   word select; 0 = left slot, 1 = right slot
// - i2s_data      out  1   serial data, changes on BCK falling edge, MSB first
// - overrun       out  1   one-cycle pulse: audio_valid while holding register still full
// - underrun      out  1   one-cycle pulse: frame load with holding register empty
// BEHAVIOUR
// - Reset: i2s_bck=0, i2s_lrck=1, i2s_data=0, overrun=0, underrun=0, div_cnt=0, bit_cnt=63,
//   holding regs=0, hold_full=0, shift reg=0, last-sample regs=0.
// - Divider: div_cnt counts 0..CLK_DIV-1; at terminal count it wraps and i2s_bck toggles.
//   A "fall event" is the toggle of i2s_bck 1->0.
// - Bit counter: bit_cnt (6 bits) increments on each fall event, wrapping 63->0.
//   i2s_lrck is registered on the fall event: 0 when new bit_cnt in 0..31, 1 when in 32..63.
// - Frame word: {L24, 8'h00, R24, 8'h00}, where X24 = {x[19:0], 4'b0000}
//   (sign preserved, full scale maps to 24-bit full scale).
// - Fall event with new bit_cnt=0: i2s_data <= sr[63]; sr <= frame word built from the holding regs
//   if hold_full (then hold_full <= 0 and last-sample regs <= holding regs), else built from the
//   last-sample regs with underrun pulsed.
// - Fall event with new bit_cnt in 1..63: i2s_data <= sr[63]; sr <= sr << 1.
//   The left MSB therefore appears at bit_cnt=1, one BCK after the LRCK transition (I2S standard).
// - Capture: audio_valid=1 loads audio_l/audio_r into the holding regs and sets hold_full.
//   If hold_full is already set and no frame load occurs in the same cycle, the new data
//   overwrites the old (latest wins) and overrun pulses.
// - Simultaneous audio_valid and frame load: the frame uses the old holding contents,
//   the new sample is captured, hold_full ends 1, and no overrun pulse.
// - Latency: a captured sample leaves on the next bit_cnt=0 load; left MSB at most 65 BCK later.
// - Reset mid-frame: all state returns to reset values asynchronously. The stream restarts with the
//   first fall event, which gives bit_cnt=0 and an all-zero frame unless a sample was captured.
// CONFIGURATION
// - SID_I2S_DITHER_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 at reset)
//   advances once per frame load. Its bits [3:0] replace the 4 zero pad bits of L24 and
//   bits [7:4] those of R24.
// - SID_I2S_DITHER_EN undefined: pad bits are 0, no LFSR logic exists, and output is bit-exact {x,4'b0}.
// STRUCTURE
// - sid package: I2S_SLOT_BITS=32, I2S_DATA_BITS=24, I2S_FRAME_BITS=64, typedef s24_t,
//   and the sid::s20_t reuse.
// - One sub-module, sid_i2s_timing: CLK_DIV divider + bit_cnt.
//   Outputs i2s_bck, the fall-event strobe, bit_cnt and frame_start (fall event with new bit_cnt=0).
// - Top module holds the holding regs, flags, shift register, lrck/data regs and the optional LFSR.
// TESTING
// - Reset then idle, CLK_DIV=2: BCK period is 4 clk. First frame: lrck 0 for 32 BCK then 1 for 32,
//   data all 0, underrun pulse at every frame start.
// - audio_l=20'h7FFFF, audio_r=20'h80000 captured once: left slot bits 1..24 = 24'h7FFFF0,
//   right slot = 24'h800000, pads 0. The next frame repeats the same words with underrun pulsed.
// - Two audio_valid strobes within one frame (L=20'h00001 then 20'h00002): overrun pulses once,
//   and the next frame carries 24'h000020.
// - audio_valid coincident with the frame_start cycle: the frame carries the prior sample,
//   the new one goes out next frame, and neither overrun nor underrun pulses.
// - Assert rst_n low at bit_cnt=40 with hold_full=1: all outputs read reset values immediately.
//   After release, bit_cnt restarts at 0 on the first fall event with zero data.
// - With SID_I2S_DITHER_EN: sample 0 gives pad nibbles equal to the LFSR[3:0]/[7:4] golden sequence
//   from 16'hACE1. Without the macro the pads are 0.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared SID audio types and I2S framing constants.
// The optional pad-bit dither in sid_audio_i2s_tx is enabled by SID_I2S_DITHER_EN.
package sid;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_DATA_BITS  = 24;
    localparam int I2S_FRAME_BITS = 64;

    typedef logic signed [19:0] s20_t;
    typedef logic signed [23:0] s24_t;

    // Widen a 20-bit sample to 24 bits by appending four pad bits.
    // Sign is kept because the MSB stays in place.
    function automatic s24_t widen_s20(input s20_t x, input logic [3:0] pad);
        return s24_t'({x, pad});
    endfunction

endpackage

// File: rtl/sid_i2s_timing.sv
// I2S bit-clock generator.
// A CLK_DIV divider toggles i2s_bck. A 6-bit bit counter advances on every BCK falling edge.
// fall_evt and frame_start are combinational strobes. Both are high in the clk cycle whose
// posedge performs the BCK 1->0 toggle, so the consumer registers update on that same edge.
module sid_i2s_timing #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       i2s_bck,
    output logic       fall_evt,
    output logic [5:0] bit_cnt,
    output logic       frame_start
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] div_cnt;
    logic          div_tc;

    assign div_tc      = (div_cnt == DW'(CLK_DIV - 1));
    assign fall_evt    = div_tc & i2s_bck;
    assign frame_start = fall_evt & (bit_cnt == 6'd63);

    // Divider, BCK toggle, and the bit counter advanced on each falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            i2s_bck <= 1'b0;
            bit_cnt <= 6'd63;
        end else begin
            if (div_tc) begin
                div_cnt <= '0;
                i2s_bck <= ~i2s_bck;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (fall_evt) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

endmodule

// File: rtl/sid_audio_i2s_tx.sv
// Stereo SID audio sink serialised as a 64-BCK I2S frame.
// Each frame holds two 32-bit slots, MSB first, with data one BCK after LRCK.
// A one-deep holding register decouples the SID sample strobe from the frame rate.
// Valid/ready semantics: there is no ready. audio_valid is a one-cycle strobe that is
// always accepted. A strobe into a full holding register overwrites it (latest wins)
// and pulses overrun. A frame load with nothing held replays the last sample and pulses underrun.
// Optional feature macro: SID_I2S_DITHER_EN (LFSR noise in the 4 pad bits of each slot).
module sid_audio_i2s_tx
    import sid::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic audio_valid,
    input  s20_t audio_l,
    input  s20_t audio_r,
    output logic i2s_bck,
    output logic i2s_lrck,
    output logic i2s_data,
    output logic overrun,
    output logic underrun
);

    logic       fall_evt;
    logic       frame_start;
    logic [5:0] bit_cnt;
    logic [5:0] bit_nxt;

    s20_t hold_l, hold_r;
    s20_t last_l, last_r;
    logic hold_full;
    s20_t src_l, src_r;
    logic [3:0] pad_l, pad_r;
    logic [I2S_FRAME_BITS-1:0] sr;
    logic [I2S_FRAME_BITS-1:0] frame_word;

    sid_i2s_timing #(.CLK_DIV(CLK_DIV)) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .i2s_bck     (i2s_bck),
        .fall_evt    (fall_evt),
        .bit_cnt     (bit_cnt),
        .frame_start (frame_start)
    );

`ifdef SID_I2S_DITHER_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR (taps 16,14,13,11), advanced once per frame load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
        end else if (frame_start) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign pad_l = lfsr[3:0];
    assign pad_r = lfsr[7:4];
`else
    assign pad_l = 4'h0;
    assign pad_r = 4'h0;
`endif

    assign bit_nxt    = bit_cnt + 6'd1;
    assign src_l      = hold_full ? hold_l : last_l;
    assign src_r      = hold_full ? hold_r : last_r;
    assign frame_word = {widen_s20(src_l, pad_l), {(I2S_SLOT_BITS - I2S_DATA_BITS){1'b0}},
                         widen_s20(src_r, pad_r), {(I2S_SLOT_BITS - I2S_DATA_BITS){1'b0}}};

    // Holding register capture and the last-sample copy taken at each frame load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_l    <= '0;
            hold_r    <= '0;
            last_l    <= '0;
            last_r    <= '0;
            hold_full <= 1'b0;
        end else begin
            if (frame_start && hold_full) begin
                last_l <= hold_l;
                last_r <= hold_r;
            end
            if (audio_valid) begin
                hold_l    <= audio_l;
                hold_r    <= audio_r;
                hold_full <= 1'b1;
            end else if (frame_start) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Shift register, serial data and word select, all updated on BCK falling edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            i2s_data <= 1'b0;
            i2s_lrck <= 1'b1;
        end else if (fall_evt) begin
            i2s_data <= sr[I2S_FRAME_BITS-1];
            i2s_lrck <= bit_nxt[5];
            if (frame_start) begin
                sr <= frame_word;
            end else begin
                sr <= {sr[I2S_FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    // One-cycle status pulses for overwritten and missing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= audio_valid & hold_full & ~frame_start;
            underrun <= frame_start & ~hold_full;
        end
    end

endmodule

// File: tb/tb_sid_audio_i2s_tx.sv
// Directed bench for sid_audio_i2s_tx with CLK_DIV=2.
// A monitor follows BCK falling edges and keeps its own bit index. Scenario tasks compare
// the recovered frames and pulse counts against hand-derived words.
module tb_sid_audio_i2s_tx;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        audio_valid = 1'b0;
  logic [19:0] audio_l = '0;
  logic [19:0] audio_r = '0;
  logic        i2s_bck, i2s_lrck, i2s_data, overrun, underrun;

  int checks = 0;
  int failures = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sid_audio_i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_valid (audio_valid),
    .audio_l     (audio_l),
    .audio_r     (audio_r),
    .i2s_bck     (i2s_bck),
    .i2s_lrck    (i2s_lrck),
    .i2s_data    (i2s_data),
    .overrun     (overrun),
    .underrun    (underrun)
  );

  // monitor: bench-side bit index, captured serial bits and pulse counts
  logic        prev_bck;
  int          tb_bit = 63;
  int          falls = 0;
  int          cyc = 0;
  int          fall_period = 0;
  int          und_cnt = 0;
  int          ovr_cnt = 0;
  logic [63:0] data_cap;
  logic [63:0] lrck_cap;
  logic [15:0] lfsr_m;
  logic [15:0] pad_src;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_bck = 1'b0;
      tb_bit   = 63;
      cyc      = 0;
      lfsr_m   = 16'hACE1;
      pad_src  = '0;
    end else begin
      cyc++;
      if (prev_bck && !i2s_bck) begin
        tb_bit = (tb_bit + 1) % 64;
        falls++;
        fall_period = cyc;
        cyc = 0;
        data_cap[tb_bit] = i2s_data;
        lrck_cap[tb_bit] = i2s_lrck;
        if (tb_bit == 0) begin
          pad_src = lfsr_m;
          lfsr_m  = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
        end
      end
      prev_bck = i2s_bck;
      if (underrun) und_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  // expected frame word for the frame loaded at the latest bit-0 edge
  function automatic logic [63:0] exp_frame(input logic [19:0] l, input logic [19:0] r);
    logic [3:0] pl;
    logic [3:0] pr;
    pl = 4'h0;
    pr = 4'h0;
`ifdef SID_I2S_DITHER_EN
    pl = pad_src[3:0];
    pr = pad_src[7:4];
`endif
    return {l, pl, 8'h00, r, pr, 8'h00};
  endfunction

  // reassemble frame bits 63..1 from the serial bits seen at bit indices 1..63
  function automatic logic [63:0] frame_got();
    logic [63:0] g;
    g = '0;
    for (int k = 1; k < 64; k++) g[64 - k] = data_cap[k];
    return g;
  endfunction

  // driver tasks
  task automatic wait_bit(input int b, input string tag);
    int start;
    int n;
    start = falls;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(falls != start && tb_bit == b) && n < 2000);
    if (falls == start || tb_bit != b) begin
      checks++;
      failures++;
      $display("FAIL %s: bit index %0d not reached, got %0d", tag, b, tb_bit);
    end
  endtask

  task automatic pulse(input logic [19:0] l, input logic [19:0] r);
    audio_l = l;
    audio_r = r;
    audio_valid = 1'b1;
    @(negedge clk);
    #1;
    audio_valid = 1'b0;
  endtask

  // scenario tasks
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (i2s_bck !== 1'b0) begin failures++; $display("FAIL reset_bck: got %b want 0", i2s_bck); end
    checks++; if (i2s_lrck !== 1'b1) begin failures++; $display("FAIL reset_lrck: got %b want 1", i2s_lrck); end
    checks++; if (i2s_data !== 1'b0) begin failures++; $display("FAIL reset_data: got %b want 0", i2s_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b want 0", underrun); end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    int und0;
    logic [63:0] got;
    und0 = und_cnt;
    wait_bit(0, "idle_start");
    checks++; if (fall_period !== 2 * CLK_DIV) begin failures++; $display("FAIL idle_bck_period: got %0d want %0d", fall_period, 2 * CLK_DIV); end
    checks++; if (und_cnt - und0 !== 1) begin failures++; $display("FAIL idle_underrun: got %0d want 1", und_cnt - und0); end
    wait_bit(63, "idle_end");
    checks++; if (lrck_cap !== {32'hFFFF_FFFF, 32'h0}) begin failures++; $display("FAIL idle_lrck: got %h want %h", lrck_cap, {32'hFFFF_FFFF, 32'h0}); end
    got = frame_got();
    checks++; if (got[63:1] !== exp_frame(20'h0, 20'h0) >> 1) begin failures++; $display("FAIL idle_data: got %h want %h", got, exp_frame(20'h0, 20'h0)); end
  endtask

  task automatic test_full_scale();
    int und0;
    logic [63:0] got;
    pulse(20'h7FFFF, 20'h80000);
    und0 = und_cnt;
    wait_bit(0, "fs_start");
    checks++; if (und_cnt - und0 !== 0) begin failures++; $display("FAIL fs_underrun: got %0d want 0", und_cnt - und0); end
    wait_bit(63, "fs_end");
    got = frame_got();
    checks++; if (got[63:1] !== exp_frame(20'h7FFFF, 20'h80000) >> 1) begin failures++; $display("FAIL fs_frame: got %h want %h", got, exp_frame(20'h7FFFF, 20'h80000)); end
    und0 = und_cnt;
    wait_bit(0, "fs_rep_start");
    checks++; if (und_cnt - und0 !== 1) begin failures++; $display("FAIL fs_rep_underrun: got %0d want 1", und_cnt - und0); end
    wait_bit(63, "fs_rep_end");
    got = frame_got();
    checks++; if (got[63:1] !== exp_frame(20'h7FFFF, 20'h80000) >> 1) begin failures++; $display("FAIL fs_rep_frame: got %h want %h", got, exp_frame(20'h7FFFF, 20'h80000)); end
  endtask

  task automatic test_overrun();
    int und0;
    int ovr0;
    logic [63:0] got;
    wait_bit(2, "ovr_mid");
    ovr0 = ovr_cnt;
    pulse(20'h00001, 20'h0);
    repeat (3) @(negedge clk);
    #1;
    pulse(20'h00002, 20'h0);
    @(negedge clk);
    #1;
    checks++; if (ovr_cnt - ovr0 !== 1) begin failures++; $display("FAIL ovr_pulse: got %0d want 1", ovr_cnt - ovr0); end
    und0 = und_cnt;
    wait_bit(0, "ovr_start");
    checks++; if (und_cnt - und0 !== 0) begin failures++; $display("FAIL ovr_underrun: got %0d want 0", und_cnt - und0); end
    wait_bit(63, "ovr_end");
    got = frame_got();
    checks++; if (got[63:1] !== exp_frame(20'h00002, 20'h0) >> 1) begin failures++; $display("FAIL ovr_frame: got %h want %h", got, exp_frame(20'h00002, 20'h0)); end
  endtask

  task automatic test_back_to_back();
    int und0;
    int ovr0;
    logic [63:0] got;
    wait_bit(5, "b2b_mid");
    pulse(20'h12345, 20'h00ABC);
    wait_bit(63, "b2b_pre");
    und0 = und_cnt;
    ovr0 = ovr_cnt;
    repeat (3) @(negedge clk);
    #1;
    pulse(20'h54321, 20'hFEDCB);
    checks++; if (tb_bit !== 0) begin failures++; $display("FAIL b2b_align: got bit %0d want 0", tb_bit); end
    checks++; if (und_cnt - und0 !== 0) begin failures++; $display("FAIL b2b_underrun: got %0d want 0", und_cnt - und0); end
    checks++; if (ovr_cnt - ovr0 !== 0) begin failures++; $display("FAIL b2b_overrun: got %0d want 0", ovr_cnt - ovr0); end
    wait_bit(63, "b2b_a_end");
    got = frame_got();
    checks++; if (got[63:1] !== exp_frame(20'h12345, 20'h00ABC) >> 1) begin failures++; $display("FAIL b2b_frame_a: got %h want %h", got, exp_frame(20'h12345, 20'h00ABC)); end
    und0 = und_cnt;
    wait_bit(0, "b2b_b_start");
    checks++; if (und_cnt - und0 !== 0) begin failures++; $display("FAIL b2b_b_underrun: got %0d want 0", und_cnt - und0); end
    wait_bit(63, "b2b_b_end");
    got = frame_got();
    checks++; if (got[63:1] !== exp_frame(20'h54321, 20'hFEDCB) >> 1) begin failures++; $display("FAIL b2b_frame_b: got %h want %h", got, exp_frame(20'h54321, 20'hFEDCB)); end
  endtask

  task automatic test_reset_mid_frame();
    int und0;
    logic [63:0] got;
    wait_bit(5, "rst_mid");
    pulse(20'h11111, 20'h22222);
    wait_bit(40, "rst_b40");
    rst_n = 1'b0;
    #1;
    checks++; if (i2s_bck !== 1'b0) begin failures++; $display("FAIL rstmid_bck: got %b want 0", i2s_bck); end
    checks++; if (i2s_lrck !== 1'b1) begin failures++; $display("FAIL rstmid_lrck: got %b want 1", i2s_lrck); end
    checks++; if (i2s_data !== 1'b0) begin failures++; $display("FAIL rstmid_data: got %b want 0", i2s_data); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rstmid_underrun: got %b want 0", underrun); end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    und0 = und_cnt;
    wait_bit(0, "rstmid_start");
    checks++; if (fall_period !== 2 * CLK_DIV) begin failures++; $display("FAIL rstmid_first_fall: got %0d cycles want %0d", fall_period, 2 * CLK_DIV); end
    checks++; if (und_cnt - und0 !== 1) begin failures++; $display("FAIL rstmid_underrun_after: got %0d want 1", und_cnt - und0); end
    checks++; if (lrck_cap[0] !== 1'b0) begin failures++; $display("FAIL rstmid_lrck0: got %b want 0", lrck_cap[0]); end
    checks++; if (data_cap[0] !== 1'b0) begin failures++; $display("FAIL rstmid_data0: got %b want 0", data_cap[0]); end
    wait_bit(63, "rstmid_end");
    got = frame_got();
    checks++; if (got[63:1] !== exp_frame(20'h0, 20'h0) >> 1) begin failures++; $display("FAIL rstmid_frame: got %h want %h", got, exp_frame(20'h0, 20'h0)); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_idle();
    test_full_scale();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
